// File: rtl/seq_pkg.sv
// Shared definitions for the colour-sequence game: capture FSM states,
// default sizing used by both the capture block and the sequence generator,
// and the colour code assignments.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PASS    = 2'd2,
    FAIL    = 2'd3
  } seq_state_t;

  localparam int DEF_COLOUR_W = 2;
  localparam int DEF_MAX_LEN  = 16;

  localparam logic [DEF_COLOUR_W-1:0] COL_RED    = 2'd0;
  localparam logic [DEF_COLOUR_W-1:0] COL_GREEN  = 2'd1;
  localparam logic [DEF_COLOUR_W-1:0] COL_BLUE   = 2'd2;
  localparam logic [DEF_COLOUR_W-1:0] COL_YELLOW = 2'd3;

endpackage

// File: rtl/seq_timer.sv
// Inactivity counter for the capture block. Counts enabled cycles since the
// last clear and raises expire on the last allowed cycle; the counter holds
// at that value so it never wraps back into the allowed window.
module seq_timer #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_r;

  // Count enabled cycles since the last clear, saturating at the last slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = enable && (cnt_r == LAST);

endmodule

// File: rtl/seq_capture.sv
// Player-input capture for the colour-sequence game. Arms on start, shifts
// accepted colour strobes into a packed register (newest entry lowest),
// checks each entry against the expected sequence as it arrives and reports
// pass, early fail on the first wrong entry, or fail on inactivity timeout.
module seq_capture
  import seq_pkg::*;
#(
  parameter int COLOUR_W    = DEF_COLOUR_W,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int TIMEOUT_CYC = 0,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        colour_in,
  input  logic [COLOUR_W-1:0]         colour_val,
  input  logic [LEN_W-1:0]            sequence_len,
  input  logic [MAX_LEN*COLOUR_W-1:0] expected_seq,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic [LEN_W-1:0]            fail_index,
  output logic [LEN_W-1:0]            count,
  output logic [MAX_LEN*COLOUR_W-1:0] sequence_val
);

  localparam int SEQ_W = MAX_LEN * COLOUR_W;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  seq_state_t           state_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     count_r;
  logic [LEN_W-1:0]     fail_index_r;
  logic [SEQ_W-1:0]     seq_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 pass_r;
  logic                 fail_r;
  logic                 timeout_r;

  logic                 in_capture_s;
  logic                 strobe_acc_s;
  logic                 tmr_clear_s;
  logic                 tmo_expire_s;
  logic [LEN_W-1:0]     start_len_s;
  logic [LEN_W-1:0]     count_inc_s;
  logic [LEN_W-1:0]     exp_idx_s;
  logic [COLOUR_W-1:0]  exp_entry_s;
  logic [SEQ_W-1:0]     seq_shift_s;

  // Decode the current strobe, clamp the requested length and select the
  // expected entry for the position about to be filled.
  always_comb begin
    in_capture_s = (state_r == CAPTURE);
    strobe_acc_s = in_capture_s && colour_in && !start;
    tmr_clear_s  = start || strobe_acc_s || !in_capture_s;
    start_len_s  = (sequence_len > MAX_LEN_L) ? MAX_LEN_L : sequence_len;
    count_inc_s  = count_r + 1'b1;
    if (count_r < MAX_LEN_L) begin
      exp_idx_s = count_r;
    end else begin
      exp_idx_s = {LEN_W{1'b0}};
    end
    exp_entry_s  = expected_seq[exp_idx_s*COLOUR_W +: COLOUR_W];
    seq_shift_s  = (seq_r << COLOUR_W) | SEQ_W'(colour_val);
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      seq_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear_s),
        .enable (in_capture_s),
        .expire (tmo_expire_s)
      );
    end else begin : g_no_timer
      logic unused_tmr_s;
      assign unused_tmr_s = tmr_clear_s;
      assign tmo_expire_s = 1'b0;
    end
  endgenerate

  // Capture FSM with registered status outputs; start overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      len_r        <= {LEN_W{1'b0}};
      count_r      <= {LEN_W{1'b0}};
      fail_index_r <= {LEN_W{1'b0}};
      seq_r        <= {SEQ_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        len_r        <= start_len_s;
        count_r      <= {LEN_W{1'b0}};
        fail_index_r <= {LEN_W{1'b0}};
        seq_r        <= {SEQ_W{1'b0}};
        fail_r       <= 1'b0;
        timeout_r    <= 1'b0;
        if (start_len_s == {LEN_W{1'b0}}) begin
          state_r <= PASS;
          pass_r  <= 1'b1;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end else begin
          state_r <= CAPTURE;
          pass_r  <= 1'b0;
          busy_r  <= 1'b1;
        end
      end else begin
        case (state_r)
          CAPTURE: begin
            if (colour_in) begin
              // The entry is recorded even when it turns out to be wrong.
              seq_r   <= seq_shift_s;
              count_r <= count_inc_s;
              if (colour_val != exp_entry_s) begin
                state_r      <= FAIL;
                fail_r       <= 1'b1;
                fail_index_r <= count_r;
                done_r       <= 1'b1;
                busy_r       <= 1'b0;
              end else if (count_inc_s == len_r) begin
                state_r <= PASS;
                pass_r  <= 1'b1;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                state_r <= CAPTURE;
              end
            end else if (tmo_expire_s) begin
              state_r   <= FAIL;
              fail_r    <= 1'b1;
              timeout_r <= 1'b1;
              done_r    <= 1'b1;
              busy_r    <= 1'b0;
            end else begin
              state_r <= CAPTURE;
            end
          end
          IDLE, PASS, FAIL: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign fail         = fail_r;
  assign timeout      = timeout_r;
  assign fail_index   = fail_index_r;
  assign count        = count_r;
  assign sequence_val = seq_r;

endmodule

// File: tb/tb_seq_capture.sv
// Directed self-checking bench for seq_capture: default sizing, an 8-cycle
// timeout variant sharing the same stimulus, and a 3-bit/5-entry variant.
module tb_seq_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Shared stimulus for the default and timeout instances.
  logic        start        = 1'b0;
  logic        colour_in    = 1'b0;
  logic [1:0]  colour_val   = 2'd0;
  logic [4:0]  sequence_len = 5'd0;
  logic [31:0] expected_seq = 32'd0;

  logic        d_busy, d_done, d_pass, d_fail, d_timeout;
  logic [4:0]  d_fail_index, d_count;
  logic [31:0] d_seq;

  logic        t_busy, t_done, t_pass, t_fail, t_timeout;
  logic [4:0]  t_fail_index, t_count;
  logic [31:0] t_seq;

  // Stimulus for the 3-bit / 5-entry instance.
  logic        c_start        = 1'b0;
  logic        c_colour_in    = 1'b0;
  logic [2:0]  c_colour_val   = 3'd0;
  logic [2:0]  c_sequence_len = 3'd0;
  logic [14:0] c_expected_seq = 15'd0;

  logic        c_busy, c_done, c_pass, c_fail, c_timeout;
  logic [2:0]  c_fail_index, c_count;
  logic [14:0] c_seq;

  int checks = 0;
  int errors = 0;

  seq_capture u_def (
    .clk(clk), .rst(rst), .start(start), .colour_in(colour_in),
    .colour_val(colour_val), .sequence_len(sequence_len),
    .expected_seq(expected_seq), .busy(d_busy), .done(d_done),
    .pass(d_pass), .fail(d_fail), .timeout(d_timeout),
    .fail_index(d_fail_index), .count(d_count), .sequence_val(d_seq)
  );

  seq_capture #(.TIMEOUT_CYC(8)) u_tmo (
    .clk(clk), .rst(rst), .start(start), .colour_in(colour_in),
    .colour_val(colour_val), .sequence_len(sequence_len),
    .expected_seq(expected_seq), .busy(t_busy), .done(t_done),
    .pass(t_pass), .fail(t_fail), .timeout(t_timeout),
    .fail_index(t_fail_index), .count(t_count), .sequence_val(t_seq)
  );

  seq_capture #(.COLOUR_W(3), .MAX_LEN(5)) u_c3 (
    .clk(clk), .rst(rst), .start(c_start), .colour_in(c_colour_in),
    .colour_val(c_colour_val), .sequence_len(c_sequence_len),
    .expected_seq(c_expected_seq), .busy(c_busy), .done(c_done),
    .pass(c_pass), .fail(c_fail), .timeout(c_timeout),
    .fail_index(c_fail_index), .count(c_count), .sequence_val(c_seq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic d_go(input logic [4:0] len);
    sequence_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic d_strobe(input logic [1:0] val);
    colour_in  = 1'b1;
    colour_val = val;
    tick();
    colour_in  = 1'b0;
  endtask

  task automatic c_go(input logic [2:0] len);
    c_sequence_len = len;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
  endtask

  task automatic c_strobe(input logic [2:0] val);
    c_colour_in  = 1'b1;
    c_colour_val = val;
    tick();
    c_colour_in  = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", d_busy, 1'b0);
    chk("rst_done", d_done, 1'b0);
    chk("rst_pass", d_pass, 1'b0);
    chk("rst_fail", d_fail, 1'b0);
    chk("rst_count", d_count, 5'd0);
    chk("rst_seq", d_seq, 32'd0);
    chk("rst_c3_busy", c_busy, 1'b0);
    chk("rst_c3_seq", c_seq, 15'd0);
    rst = 1'b0;
    tick();

    // Correct sequence 1,2,3,0 on separated cycles
    expected_seq = 32'h0000_0039;
    d_go(5'd4);
    chk("start_busy", d_busy, 1'b1);
    chk("start_count", d_count, 5'd0);
    chk("start_done", d_done, 1'b0);
    d_strobe(2'd1); tick();
    d_strobe(2'd2); tick();
    d_strobe(2'd3);
    chk("pass_mid_count", d_count, 5'd3);
    chk("pass_mid_pass", d_pass, 1'b0);
    tick();
    d_strobe(2'd0);
    chk("pass_done", d_done, 1'b1);
    chk("pass_pass", d_pass, 1'b1);
    chk("pass_busy", d_busy, 1'b0);
    chk("pass_count", d_count, 5'd4);
    chk("pass_seq", d_seq, 32'h0000_006C);
    tick();
    chk("pass_done_once", d_done, 1'b0);
    chk("pass_sticky", d_pass, 1'b1);
    d_strobe(2'd1);
    chk("pass_ignore_strobe", d_count, 5'd4);

    // Mismatch on the second entry
    d_go(5'd4);
    chk("restart_clears_pass", d_pass, 1'b0);
    d_strobe(2'd1);
    d_strobe(2'd3);
    chk("mm_fail", d_fail, 1'b1);
    chk("mm_done", d_done, 1'b1);
    chk("mm_index", d_fail_index, 5'd1);
    chk("mm_timeout", d_timeout, 1'b0);
    chk("mm_count", d_count, 5'd2);
    chk("mm_seq", d_seq, 32'h0000_0007);
    chk("mm_pass", d_pass, 1'b0);
    d_strobe(2'd2);
    chk("mm_ignore_count", d_count, 5'd2);
    chk("mm_done_once", d_done, 1'b0);

    // Timeout after 8 idle CAPTURE cycles
    d_go(5'd4);
    for (int i = 1; i <= 7; i++) begin
      chk("tmo_not_yet", t_fail, 1'b0);
      tick();
    end
    chk("tmo_cycle8_busy", t_busy, 1'b1);
    tick();
    chk("tmo_fail", t_fail, 1'b1);
    chk("tmo_timeout", t_timeout, 1'b1);
    chk("tmo_done", t_done, 1'b1);
    chk("tmo_index", t_fail_index, 5'd0);
    chk("tmo_busy", t_busy, 1'b0);
    chk("tmo_disabled_default", d_fail, 1'b0);
    chk("tmo_disabled_busy", d_busy, 1'b1);

    // Strobe on the 8th cycle wins over the timeout
    d_go(5'd4);
    repeat (7) tick();
    d_strobe(2'd1);
    chk("tmo_strobe_fail", t_fail, 1'b0);
    chk("tmo_strobe_count", t_count, 5'd1);
    repeat (7) tick();
    chk("tmo_rearm_not_yet", t_fail, 1'b0);
    tick();
    chk("tmo_rearm_fail", t_fail, 1'b1);
    chk("tmo_rearm_timeout", t_timeout, 1'b1);
    chk("tmo_rearm_index", t_fail_index, 5'd0);

    // Zero length passes straight away
    d_go(5'd0);
    chk("len0_pass", d_pass, 1'b1);
    chk("len0_done", d_done, 1'b1);
    chk("len0_busy", d_busy, 1'b0);
    chk("len0_count", d_count, 5'd0);

    // Over-long length clamps to MAX_LEN; back-to-back strobes
    expected_seq = 32'hE4E4_E4E4;
    d_go(5'd19);
    for (int i = 0; i < 16; i++) begin
      colour_in  = 1'b1;
      colour_val = 2'(i);
      tick();
      if (i == 14) begin
        chk("clamp_count15", d_count, 5'd15);
        chk("clamp_not_pass", d_pass, 1'b0);
      end
    end
    colour_in = 1'b0;
    chk("clamp_pass", d_pass, 1'b1);
    chk("clamp_done", d_done, 1'b1);
    chk("clamp_count", d_count, 5'd16);
    chk("clamp_seq", d_seq, 32'h1B1B_1B1B);
    d_strobe(2'd0);
    chk("clamp_no_more", d_count, 5'd16);

    // start together with a strobe restarts and drops the strobe
    expected_seq = 32'h0000_0039;
    d_go(5'd4);
    d_strobe(2'd1);
    d_strobe(2'd2);
    chk("rs_count2", d_count, 5'd2);
    start      = 1'b1;
    colour_in  = 1'b1;
    colour_val = 2'd3;
    tick();
    start     = 1'b0;
    colour_in = 1'b0;
    chk("rs_count", d_count, 5'd0);
    chk("rs_seq", d_seq, 32'd0);
    chk("rs_busy", d_busy, 1'b1);
    chk("rs_done", d_done, 1'b0);
    d_strobe(2'd1);
    chk("rs_after_count", d_count, 5'd1);
    chk("rs_after_seq", d_seq, 32'h0000_0001);

    // Reset in the middle of a capture
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", d_busy, 1'b0);
    chk("mrst_count", d_count, 5'd0);
    chk("mrst_seq", d_seq, 32'd0);
    chk("mrst_done", d_done, 1'b0);
    chk("mrst_fail", d_fail, 1'b0);
    tick();
    chk("mrst_done_later", d_done, 1'b0);
    chk("mrst_idle", d_busy, 1'b0);

    // 3-bit colours, 5 entries: 5,7,2,6,4 with length 7 clamped to 5
    c_expected_seq = 15'h4CBD;
    c_go(3'd7);
    c_strobe(3'd5);
    c_strobe(3'd7);
    c_strobe(3'd2);
    chk("c3_mid_seq", c_seq, 15'h017A);
    chk("c3_mid_count", c_count, 3'd3);
    c_strobe(3'd6);
    chk("c3_not_pass", c_pass, 1'b0);
    c_strobe(3'd4);
    chk("c3_pass", c_pass, 1'b1);
    chk("c3_done", c_done, 1'b1);
    chk("c3_count", c_count, 3'd5);
    chk("c3_seq", c_seq, 15'h5EB4);
    c_strobe(3'd1);
    chk("c3_no_more", c_seq, 15'h5EB4);

    // 3-bit colours, wrong first entry
    c_go(3'd5);
    c_strobe(3'd4);
    chk("c3_mm_fail", c_fail, 1'b1);
    chk("c3_mm_index", c_fail_index, 3'd0);
    chk("c3_mm_count", c_count, 3'd1);
    chk("c3_mm_seq", c_seq, 15'h0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
